// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: mode-0, 8-bit SPI master whose bus is shared by NREQ requesters.
// Optional macro SPI_ARB_ROUND_ROBIN_EN selects round-robin arbitration; without it, the lowest index wins.
module spi_master_arbiter #(
   parameter int NREQ    = 2,
   parameter int CLK_DIV = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] tx_data,
   output logic [NREQ-1:0]   grant,
   output logic              done,
   output logic [7:0]        rx_data,
   output logic              busy,
   output logic              sclk,
   output logic [NREQ-1:0]   CS,
   output logic              MOSI,
   input  logic              MISO
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int HW = $clog2(CLK_DIV + 1);
   localparam logic [HW-1:0] HRELOAD = HW'(CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

   state_t          state;
   logic [HW-1:0]   hcnt;
   logic [3:0]      bcnt;
   logic [7:0]      tx_sh;
   logic [7:0]      rx_sh;
   logic [PW-1:0]   win_idx;
   logic [NREQ-1:0] win_onehot;
   logic [7:0]      win_byte;

`ifdef SPI_ARB_ROUND_ROBIN_EN
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   ptr_next;

   assign ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
`endif

   always_comb begin
      win_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (req[i]) win_idx = PW'(i);
`ifdef SPI_ARB_ROUND_ROBIN_EN
      // A requester at or above the pointer outranks every requester below it.
      for (int i = NREQ - 1; i >= 0; i--)
         if (req[i] && (PW'(i) >= ptr)) win_idx = PW'(i);
`endif
   end

   always_comb begin
      win_onehot = '0;
      win_byte   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (PW'(i) == win_idx) begin
            win_onehot[i] = 1'b1;
            win_byte      = tx_data[8*i +: 8];
         end
      end
   end

   // hcnt counts down each phase; bcnt numbers the 16 sclk half-periods of SHIFT.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         grant   <= '0;
         done    <= 1'b0;
         rx_data <= '0;
         busy    <= 1'b0;
         sclk    <= 1'b0;
         CS      <= '1;
         MOSI    <= 1'b0;
         hcnt    <= '0;
         bcnt    <= '0;
         tx_sh   <= '0;
         rx_sh   <= '0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
         ptr     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (|req) begin
                  grant <= win_onehot;
                  CS    <= ~win_onehot;
                  tx_sh <= win_byte;
                  MOSI  <= win_byte[7];
                  rx_sh <= '0;
                  sclk  <= 1'b0;
                  busy  <= 1'b1;
                  hcnt  <= HRELOAD;
                  state <= SETUP;
`ifdef SPI_ARB_ROUND_ROBIN_EN
                  ptr   <= ptr_next;
`endif
               end
            end
            SETUP: begin
               if (hcnt == '0) begin
                  hcnt  <= HRELOAD;
                  bcnt  <= '0;
                  state <= SHIFT;
               end else begin
                  hcnt <= hcnt - HW'(1);
               end
            end
            SHIFT: begin
               if (hcnt == '0) begin
                  hcnt <= HRELOAD;
                  sclk <= ~sclk;
                  bcnt <= bcnt + 4'd1;
                  if (!sclk) begin
                     rx_sh <= {rx_sh[6:0], MISO};
                  end else if (bcnt != 4'd15) begin
                     tx_sh <= {tx_sh[6:0], 1'b0};
                     MOSI  <= tx_sh[6];
                  end
                  if (bcnt == 4'd15) state <= HOLD;
               end else begin
                  hcnt <= hcnt - HW'(1);
               end
            end
            HOLD: begin
               if (hcnt == '0) begin
                  CS      <= '1;
                  MOSI    <= 1'b0;
                  done    <= 1'b1;
                  rx_data <= rx_sh;
                  state   <= DONE;
               end else begin
                  hcnt <= hcnt - HW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               grant <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: table-driven and randomized checks of spi_master_arbiter (NREQ=2, CLK_DIV=2 and 1).
// Expected grants follow SPI_ARB_ROUND_ROBIN_EN when it is defined, fixed priority otherwise.
module tb_spi_master_arbiter;
   localparam int NREQ = 2;
   localparam int DIV  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [1:0]  req;
   logic [15:0] tx_data;
   logic [1:0]  grant, CS;
   logic        done, busy, sclk, MOSI, MISO;
   logic [7:0]  rx_data;

   logic [1:0]  req1;
   logic [15:0] tx1;
   logic [1:0]  grant1, cs1;
   logic        done1, busy1, sclk1, mosi1;
   logic [7:0]  rx1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_done_cyc = 0;
   int mosi_idle_err = 0;

   spi_master_arbiter #(.NREQ(NREQ), .CLK_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .req(req), .tx_data(tx_data), .grant(grant), .done(done),
      .rx_data(rx_data), .busy(busy), .sclk(sclk), .CS(CS), .MOSI(MOSI), .MISO(MISO));

   spi_master_arbiter #(.NREQ(NREQ), .CLK_DIV(1)) dut_div1 (
      .clk(clk), .reset(reset), .req(req1), .tx_data(tx1), .grant(grant1), .done(done1),
      .rx_data(rx1), .busy(busy1), .sclk(sclk1), .CS(cs1), .MOSI(mosi1), .MISO(1'b1));

   always @(posedge clk) cyc++;

   // Mode-0 slave: first bit ready when CS falls, next bit after every falling sclk.
   logic [7:0] slave_tx = 8'h00;
   int         fall_cnt = 0;
   logic       cs_sel, cs1_sel;
   assign cs_sel  = (CS != 2'b11);
   assign cs1_sel = (cs1 != 2'b11);
   always @(negedge sclk or negedge cs_sel)
      if (!cs_sel) fall_cnt = 0;
      else fall_cnt++;
   assign MISO = (cs_sel && fall_cnt < 8) ? slave_tx[3'(7 - fall_cnt)] : 1'b0;

   logic [7:0] mosi_cap, mosi1_cap;
   int         rise_cnt = 0;
   always @(posedge sclk or posedge cs_sel)
      if (!sclk) begin
         mosi_cap = 8'h00;
         rise_cnt = 0;
      end else begin
         mosi_cap = {mosi_cap[6:0], MOSI};
         rise_cnt++;
      end
   always @(posedge sclk1 or posedge cs1_sel)
      if (!sclk1) mosi1_cap = 8'h00;
      else mosi1_cap = {mosi1_cap[6:0], mosi1};

   always @(negedge clk)
      if (!reset && ((CS == 2'b11 && MOSI !== 1'b0) || (cs1 == 2'b11 && mosi1 !== 1'b0)))
         mosi_idle_err++;

   typedef struct packed {
      logic [1:0] r;
      logic [7:0] t0;
      logic [7:0] t1;
      logic [7:0] s;
      logic [1:0] exp_g;
      logic [7:0] exp_mosi;
   } vec_t;
   vec_t vecs[6];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One whole transfer on the CLK_DIV=2 instance; done_r is driven onto req during the done cycle.
   task automatic applyStimulus(input logic [1:0] r, input logic [7:0] t0, input logic [7:0] t1,
                                input logic [7:0] s, input logic [1:0] exp_g, input logic [7:0] exp_mosi,
                                input bit chk_gap, input bit drop_mid, input logic [1:0] done_r,
                                input string tag);
      int         g_cyc, d_cyc, n, cs_err;
      logic [1:0] g0, exp_cs;
      bit         seen;
      req      = r;
      tx_data  = {t1, t0};
      slave_tx = s;
      exp_cs   = ~exp_g;
      n = 0; seen = 0;
      while (!seen && n < 60) begin
         @(negedge clk); n++;
         if (grant != 2'b00) seen = 1;
      end
      if (!seen) begin
         checkOutput({tag, "_grant_timeout"}, 32'd0, 32'd1);
         return;
      end
      g_cyc = cyc;
      g0    = grant;
      checkOutput({tag, "_grant"}, grant, exp_g);
      checkOutput({tag, "_cs_at_grant"}, CS, exp_cs);
      if (chk_gap) checkOutput({tag, "_cs_gap"}, g_cyc - last_done_cyc, 32'd2);
      n = 0; seen = 0; cs_err = 0;
      while (!seen && n < 100) begin
         @(negedge clk); n++;
         if (done) seen = 1;
         else begin
            if (CS !== ~g0 || grant !== g0 || busy !== 1'b1) cs_err++;
            if (drop_mid && rise_cnt == 2) req = 2'b00;
         end
      end
      if (!seen) begin
         checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
         return;
      end
      d_cyc = cyc;
      last_done_cyc = d_cyc;
      checkOutput({tag, "_latency"}, d_cyc - g_cyc, 18 * DIV);
      checkOutput({tag, "_grant_at_done"}, grant, exp_g);
      checkOutput({tag, "_cs_at_done"}, CS, 2'b11);
      checkOutput({tag, "_rx"}, rx_data, s);
      checkOutput({tag, "_mosi"}, mosi_cap, exp_mosi);
      checkOutput({tag, "_rises"}, rise_cnt, 32'd8);
      checkOutput({tag, "_bus_hold"}, cs_err, 32'd0);
      req = done_r;
      @(negedge clk);
      checkOutput({tag, "_done_pulse"}, {done, grant}, 3'b000);
   endtask

   initial begin
      int         n, regrant, g, tog, win;
      logic       prev;
      logic [1:0] r, exp_g;
      logic [7:0] t0, t1, s;
      int         w;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      int         mdl_ptr;
`endif

      vecs[0] = '{2'b01, 8'hAA, 8'h55, 8'hD4, 2'b01, 8'hAA};
`ifdef SPI_ARB_ROUND_ROBIN_EN
      vecs[1] = '{2'b11, 8'h3C, 8'hC3, 8'h5A, 2'b10, 8'hC3};
      vecs[2] = '{2'b11, 8'h0F, 8'hF0, 8'h81, 2'b01, 8'h0F};
      vecs[3] = '{2'b11, 8'h12, 8'h34, 8'h7E, 2'b10, 8'h34};
`else
      vecs[1] = '{2'b11, 8'h3C, 8'hC3, 8'h5A, 2'b01, 8'h3C};
      vecs[2] = '{2'b11, 8'h0F, 8'hF0, 8'h81, 2'b01, 8'h0F};
      vecs[3] = '{2'b11, 8'h12, 8'h34, 8'h7E, 2'b01, 8'h12};
`endif
      vecs[4] = '{2'b10, 8'hFF, 8'h00, 8'h00, 2'b10, 8'h00};
      vecs[5] = '{2'b11, 8'h96, 8'h69, 8'hFF, 2'b01, 8'h96};

      reset = 1'b1; req = 2'b00; tx_data = 16'h0000; req1 = 2'b00; tx1 = 16'h0000;
      repeat (3) @(negedge clk);
      checkOutput("reset_grant", grant, 2'b00);
      checkOutput("reset_cs", CS, 2'b11);
      checkOutput("reset_outs", {done, busy, sclk, MOSI, rx_data}, 12'h000);
      reset = 1'b0;

      for (int i = 0; i < 6; i++)
         applyStimulus(vecs[i].r, vecs[i].t0, vecs[i].t1, vecs[i].s, vecs[i].exp_g, vecs[i].exp_mosi,
                       i > 0, 1'b0, (i < 5) ? vecs[i+1].r : 2'b00, $sformatf("vec%0d", i));

      // Dropping req mid-transfer still completes the transfer, and nothing is re-granted.
      applyStimulus(2'b01, 8'h5A, 8'h00, 8'h3C, 2'b01, 8'h5A, 1'b1, 1'b1, 2'b00, "drop_mid");
      regrant = 0;
      repeat (40) begin
         @(negedge clk);
         if (grant != 2'b00) regrant++;
      end
      checkOutput("drop_mid_no_regrant", regrant, 32'd0);

      req = 2'b01; tx_data = 16'h00C5; slave_tx = 8'hA7; n = 0;
      while (!(grant != 2'b00 && rise_cnt == 4) && n < 200) begin
         @(negedge clk); n++;
      end
      checkOutput("rst_mid_reached", rise_cnt, 32'd4);
      reset = 1'b1; req = 2'b00;
      @(negedge clk);
      checkOutput("rst_mid_cs", CS, 2'b11);
      checkOutput("rst_mid_outs", {grant, done, busy, sclk, MOSI}, 6'h00);
      checkOutput("rst_mid_rx", rx_data, 8'h00);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_mid_no_done", {done, busy}, 2'b00);
      applyStimulus(2'b01, 8'h5A, 8'h00, 8'hC3, 2'b01, 8'h5A, 1'b0, 1'b0, 2'b00, "post_rst");

      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      mdl_ptr = 0;
`endif
      for (int i = 0; i < 12; i++) begin
         r  = 2'($urandom_range(1, 3));
         t0 = 8'($urandom);
         t1 = 8'($urandom);
         s  = 8'($urandom);
         w  = -1;
`ifdef SPI_ARB_ROUND_ROBIN_EN
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && r[(mdl_ptr + k) % NREQ]) w = (mdl_ptr + k) % NREQ;
         mdl_ptr = (w + 1) % NREQ;
`else
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && r[k]) w = k;
`endif
         exp_g = 2'(1 << w);
         applyStimulus(r, t0, t1, s, exp_g, (w == 0) ? t0 : t1, i > 0, 1'b0, 2'b00,
                       $sformatf("rnd%0d", i));
      end

      req1 = 2'b01; tx1 = 16'h0001; n = 0;
      while (grant1 == 2'b00 && n < 20) begin
         @(negedge clk); n++;
      end
      checkOutput("div1_grant", grant1, 2'b01);
      checkOutput("div1_busy", busy1, 1'b1);
      req1 = 2'b00;
      g = cyc; prev = sclk1; tog = 0; win = 0; n = 0;
      while (!done1 && n < 50) begin
         @(negedge clk); n++;
         if (sclk1 !== prev) begin
            tog++;
            if (cyc >= g + 2 && cyc <= g + 17) win++;
         end
         prev = sclk1;
      end
      checkOutput("div1_latency", cyc - g, 32'd18);
      checkOutput("div1_rx", rx1, 8'hFF);
      checkOutput("div1_mosi", mosi1_cap, 8'h01);
      checkOutput("div1_toggles", tog, 32'd16);
      checkOutput("div1_toggle_every_cycle", win, 32'd16);
      checkOutput("div1_grant_at_done", grant1, 2'b01);

      @(negedge clk);
      checkOutput("mosi_idle_low", mosi_idle_err, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
